// File: rtl/keypad_scanner.sv
// 4x4 keypad scan controller: walks active-low columns, samples synchronized rows,
// debounces over whole scans and emits one key_valid pulse per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       RST_BTN,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_e;

  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [15:0]   snapshot;
  logic [15:0]   snap_next;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_next;
  cand_e         prev_kind;
  logic [3:0]    prev_key;
  cand_e         acc_kind;
  logic [3:0]    acc_key;
  cand_e         cand_kind;
  logic [3:0]    cand_key;
  logic [4:0]    n_set;
  logic          sample;
  logic          scan_start;
  logic          scan_end;
  logic          accept;

  assign sample     = (dwell == DWELL_LAST);
  assign scan_start = (col_idx == 2'd0) && (dwell == '0);
  assign scan_end   = sample && (col_idx == 2'd3);
  assign col        = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      dwell    <= '0;
      col_idx  <= 2'd0;
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      snapshot <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      snapshot <= snap_next;
      if (sample) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // The final column's sample is merged combinationally so the full scan is classified on the same edge.
  always_comb begin
    snap_next = snapshot;
    if (scan_start)
      snap_next = '0;
    if (sample)
      snap_next[{col_idx, 2'b00} +: 4] = ~row_sync;

    n_set     = 5'd0;
    cand_key  = 4'd0;
    cand_kind = CAND_NONE;
    for (int b = 0; b < 16; b++) begin
      if (snap_next[b]) begin
        n_set    = n_set + 5'd1;
        cand_key = {b[1:0], b[3:2]};
      end
    end
    if (n_set == 5'd1) begin
      cand_kind = CAND_KEY;
    end else if (n_set > 5'd1) begin
      cand_kind = CAND_MULTI;
      cand_key  = 4'd0;
    end

    if ((cand_kind == prev_kind) && (cand_key == prev_key))
      stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SW'(1);
    else
      stable_next = SW'(1);

    accept = (stable_next == STABLE_MAX) &&
             !((cand_kind == acc_kind) && (cand_key == acc_key));
  end

  always_ff @(posedge clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      stable_cnt <= '0;
      prev_kind  <= CAND_NONE;
      prev_key   <= 4'd0;
      acc_kind   <= CAND_NONE;
      acc_key    <= 4'd0;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        stable_cnt <= stable_next;
        prev_kind  <= cand_kind;
        prev_key   <= cand_key;
        if (accept) begin
          case (cand_kind)
            CAND_KEY: begin
              acc_kind  <= CAND_KEY;
              acc_key   <= cand_key;
              key_code  <= cand_key;
              key_held  <= 1'b1;
              key_valid <= 1'b1;
            end
            CAND_NONE: begin
              acc_kind <= CAND_NONE;
              acc_key  <= 4'd0;
              key_held <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, timed scoreboard of expected pulses, directed scenarios.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .RST_BTN(rst_n),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key (r,c) is bit r*4+c of pressed; it pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc <= 0;
    else
      cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] keys, input bit expect_pulse,
                                input logic [3:0] code, input int at_cyc);
    exp_t e;
    pressed = keys;
    if (expect_pulse) begin
      e.code = code;
      e.cyc  = at_cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && key_valid) begin
      if (sb_q.size() == 0) begin
        check_output("spurious_pulse", key_valid, 0);
      end else begin
        e = sb_q.pop_front();
        check_output("pulse_code", key_code, e.code);
        check_output("pulse_cycle", cyc, e.cyc);
        check_output("pulse_held", key_held, 1);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    pressed = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);

    check_output("reset_col", col, 4'b1110);
    check_output("reset_code", key_code, 0);
    check_output("reset_valid", key_valid, 0);
    check_output("reset_held", key_held, 0);

    rst_n = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      wait_cyc(c);
      check_output($sformatf("col_walk_%0d", c), col, ~(4'b0001 << ((c / 4) % 4)) & 4'hF);
    end

    // Single press of (1,2) from the scan boundary at cycle 16.
    apply_stimulus(16'h0040, 1'b1, 4'd6, 48);
    wait_cyc(47);
    check_output("press_held_early", key_held, 0);
    wait_cyc(49);
    check_output("press_held", key_held, 1);
    check_output("press_code", key_code, 6);
    wait_cyc(208);
    check_output("hold_held", key_held, 1);

    apply_stimulus(16'h0000, 1'b0, 4'd0, 0);
    wait_cyc(239);
    check_output("release_held_early", key_held, 1);
    wait_cyc(240);
    check_output("release_held", key_held, 0);
    check_output("release_code", key_code, 6);

    // Key (0,0) bouncing on alternate scans.
    for (int i = 0; i < 8; i++) begin
      wait_cyc(240 + 16 * i);
      apply_stimulus((i % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0, 4'd0, 0);
    end
    wait_cyc(368);
    apply_stimulus(16'h0000, 1'b0, 4'd0, 0);
    check_output("bounce_held", key_held, 0);
    check_output("bounce_code", key_code, 6);

    // (2,1) and (3,3) together, then (3,3) alone.
    apply_stimulus(16'h8200, 1'b0, 4'd0, 0);
    wait_cyc(432);
    check_output("multi_held", key_held, 0);
    check_output("multi_code", key_code, 6);
    apply_stimulus(16'h8000, 1'b1, 4'd15, 464);
    wait_cyc(465);
    check_output("single_after_multi_held", key_held, 1);
    check_output("single_after_multi_code", key_code, 15);
    wait_cyc(480);
    apply_stimulus(16'h0000, 1'b0, 4'd0, 0);
    wait_cyc(512);
    check_output("multi_release_held", key_held, 0);

    // Press (0,1), reset one scan into the debounce, release reset with the key still down.
    apply_stimulus(16'h0002, 1'b0, 4'd0, 0);
    wait_cyc(528);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midreset_col", col, 4'b1110);
    check_output("midreset_code", key_code, 0);
    check_output("midreset_valid", key_valid, 0);
    check_output("midreset_held", key_held, 0);
    rst_n = 1'b1;
    apply_stimulus(16'h0002, 1'b1, 4'd1, 32);
    wait_cyc(33);
    check_output("after_reset_held", key_held, 1);
    check_output("after_reset_code", key_code, 1);

    wait_cyc(40);
    check_output("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
